wb_csr_ctrl: RTL and testbench

Writeback-stage commit controller driving the initiator side of the CSR file interface. Latches one instruction from MEM, performs its CSR read/write (csrrd/csrwr/csrxchg), signals exceptions and ertn to the CSR file, and writes the register file. On an exception or ertn it cancels younger instructions and holds a redirect request to IF until acknowledged.

---
 rtl/wb_csr_ctrl.sv | 225 ++++++++++++++++++++++
 tb/tb_wb_csr_ctrl.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_csr_ctrl.sv
// ---------------------------------------------------------------------------
// wb_csr_ctrl
// Writeback-stage commit controller. It latches one instruction from MEM and
// commits it in the following cycle. A commit performs the instruction's CSR
// access (csrrd/csrwr/csrxchg), reports exceptions and ertn to the CSR file,
// and writes the GPR file. An exception or ertn cancels all younger
// instructions and holds a redirect request to IF until IF acknowledges it.
//
// Optional feature (macro CSR_WR_FLUSH_EN):
//   When defined, a committed csrwr/csrxchg without an exception also flushes
//   and redirects IF to pc+4. This makes younger instructions re-fetch under
//   the new CSR state. When undefined, CSR writes never flush.
//
// Ports
//   clk, resetn                  clock, asynchronous active-low reset
//   ms_*                         instruction handed over by MEM
//   ws_allowin                   WB accepts ms_* (always 1)
//   csr_re/csr_num/csr_rvalue    CSR read (csr_rvalue is combinational)
//   csr_we/csr_wmask/csr_wvalue  CSR write
//   csr_eentry/csr_era           exception entry / return address from CSRs
//   wb_ex/wb_ecode/wb_esubcode/wb_pc  exception commit to CSR file
//   eret_flush                   ertn commit to CSR file
//   rf_we/rf_waddr/rf_wdata      GPR write port
//   ms_flush                     cancel all younger in-flight instructions
//   flush_req/flush_pc/flush_ack redirect handshake with IF
// ---------------------------------------------------------------------------
module wb_csr_ctrl (
  input  logic        clk,
  input  logic        resetn,
  // MEM -> WB
  input  logic        ms_valid,
  input  logic [31:0] ms_pc,
  input  logic [1:0]  ms_csr_op,
  input  logic [13:0] ms_csr_num,
  input  logic [31:0] ms_rj_value,
  input  logic [31:0] ms_rkd_value,
  input  logic        ms_ertn,
  input  logic        ms_ex,
  input  logic [5:0]  ms_ecode,
  input  logic [8:0]  ms_esubcode,
  input  logic        ms_gr_we,
  input  logic [4:0]  ms_dest,
  input  logic [31:0] ms_result,
  output logic        ws_allowin,
  // CSR file
  output logic        csr_re,
  output logic [13:0] csr_num,
  input  logic [31:0] csr_rvalue,
  output logic        csr_we,
  output logic [31:0] csr_wmask,
  output logic [31:0] csr_wvalue,
  input  logic [31:0] csr_eentry,
  input  logic [31:0] csr_era,
  output logic        wb_ex,
  output logic [5:0]  wb_ecode,
  output logic [8:0]  wb_esubcode,
  output logic [31:0] wb_pc,
  output logic        eret_flush,
  // GPR file
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  // Pipeline control
  output logic        ms_flush,
  output logic        flush_req,
  output logic [31:0] flush_pc,
  input  logic        flush_ack
);

  localparam int unsigned XLEN    = 32;
  localparam int unsigned CSR_NW  = 14;
  localparam int unsigned ECODE_W = 6;
  localparam int unsigned ESUB_W  = 9;
  localparam int unsigned REG_AW  = 5;

  localparam logic [1:0] CSR_NONE = 2'b00;
  localparam logic [1:0] CSR_WR   = 2'b10;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_FLUSH = 1'b1
  } state_e;

  // Instruction held in WB between latch and commit
  typedef struct packed {
    logic [XLEN-1:0]    pc;
    logic [1:0]         csr_op;
    logic [CSR_NW-1:0]  csr_num;
    logic [XLEN-1:0]    rj_value;
    logic [XLEN-1:0]    rkd_value;
    logic               ertn;
    logic               ex;
    logic [ECODE_W-1:0] ecode;
    logic [ESUB_W-1:0]  esubcode;
    logic               gr_we;
    logic [REG_AW-1:0]  dest;
    logic [XLEN-1:0]    result;
  } ws_inst_t;

  state_e          state_q,    state_d;
  logic            ws_valid_q, ws_valid_d;
  ws_inst_t        inst_q,     inst_d;
  logic [XLEN-1:0] flush_pc_q, flush_pc_d;

  // Commit decode, priority ex > ertn > CSR op > plain
  logic commit_c;
  logic do_ex_c;
  logic do_ertn_c;
  logic do_csr_c;
  logic do_csr_wr_c;
  logic do_wr_flush_c;
  logic commit_flush_c;

  always_comb begin
    commit_c    = ws_valid_q && (state_q == ST_IDLE);
    do_ex_c     = commit_c && inst_q.ex;
    do_ertn_c   = commit_c && !inst_q.ex && inst_q.ertn;
    do_csr_c    = commit_c && !inst_q.ex && !inst_q.ertn && (inst_q.csr_op != CSR_NONE);
    // csrwr (10) and csrxchg (11) both write
    do_csr_wr_c = do_csr_c && inst_q.csr_op[1];
`ifdef CSR_WR_FLUSH_EN
    do_wr_flush_c = do_csr_wr_c;
`else
    do_wr_flush_c = 1'b0;
`endif
    commit_flush_c = do_ex_c || do_ertn_c || do_wr_flush_c;
  end

  // Next state, latch and redirect target
  always_comb begin
    state_d    = state_q;
    ws_valid_d = 1'b0;
    inst_d     = inst_q;
    flush_pc_d = flush_pc_q;

    case (state_q)
      ST_IDLE: begin
        if (commit_flush_c) begin
          // The instruction MEM presents now is younger and is dropped
          state_d = ST_FLUSH;
          if (do_ex_c) begin
            flush_pc_d = csr_eentry;
          end else if (do_ertn_c) begin
            flush_pc_d = csr_era;
          end else begin
            flush_pc_d = inst_q.pc + XLEN'(4);
          end
        end else if (ms_valid) begin
          ws_valid_d       = 1'b1;
          inst_d.pc        = ms_pc;
          inst_d.csr_op    = ms_csr_op;
          inst_d.csr_num   = ms_csr_num;
          inst_d.rj_value  = ms_rj_value;
          inst_d.rkd_value = ms_rkd_value;
          inst_d.ertn      = ms_ertn;
          inst_d.ex        = ms_ex;
          inst_d.ecode     = ms_ecode;
          inst_d.esubcode  = ms_esubcode;
          inst_d.gr_we     = ms_gr_we;
          inst_d.dest      = ms_dest;
          inst_d.result    = ms_result;
        end
      end
      ST_FLUSH: begin
        // MEM contents are wrong-path here; hold the redirect until taken
        if (flush_ack) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= ST_IDLE;
      ws_valid_q <= 1'b0;
      inst_q     <= '0;
      flush_pc_q <= '0;
    end else begin
      state_q    <= state_d;
      ws_valid_q <= ws_valid_d;
      inst_q     <= inst_d;
      flush_pc_q <= flush_pc_d;
    end
  end

  // Commit outputs, all forced to zero outside a commit cycle
  always_comb begin
    ws_allowin  = 1'b1;

    csr_re      = do_csr_c;
    csr_num     = inst_q.csr_num;
    csr_we      = do_csr_wr_c;
    csr_wmask   = '0;
    csr_wvalue  = '0;
    if (do_csr_wr_c) begin
      csr_wmask  = (inst_q.csr_op == CSR_WR) ? {XLEN{1'b1}} : inst_q.rj_value;
      csr_wvalue = inst_q.rkd_value;
    end

    wb_ex       = do_ex_c;
    wb_ecode    = do_ex_c ? inst_q.ecode    : '0;
    wb_esubcode = do_ex_c ? inst_q.esubcode : '0;
    wb_pc       = do_ex_c ? inst_q.pc       : '0;
    eret_flush  = do_ertn_c;

    rf_we       = commit_c && inst_q.gr_we && !inst_q.ex;
    rf_waddr    = '0;
    rf_wdata    = '0;
    if (rf_we) begin
      rf_waddr = inst_q.dest;
      // CSR instructions return the value before the write
      rf_wdata = do_csr_c ? csr_rvalue : inst_q.result;
    end

    flush_req   = (state_q == ST_FLUSH);
    flush_pc    = flush_pc_q;
    ms_flush    = flush_req || commit_flush_c;
  end

endmodule

// File: tb/tb_wb_csr_ctrl.sv
// ---------------------------------------------------------------------------
// tb_wb_csr_ctrl
// Self-checking bench for wb_csr_ctrl: directed scenarios followed by random
// traffic, all compared every cycle against a transaction-level model of WB.
// ---------------------------------------------------------------------------
module tb_wb_csr_ctrl;

  logic        clk = 1'b0;
  logic        resetn;
  logic        ms_valid;
  logic [31:0] ms_pc;
  logic [1:0]  ms_csr_op;
  logic [13:0] ms_csr_num;
  logic [31:0] ms_rj_value;
  logic [31:0] ms_rkd_value;
  logic        ms_ertn;
  logic        ms_ex;
  logic [5:0]  ms_ecode;
  logic [8:0]  ms_esubcode;
  logic        ms_gr_we;
  logic [4:0]  ms_dest;
  logic [31:0] ms_result;
  logic        ws_allowin;
  logic        csr_re;
  logic [13:0] csr_num;
  logic [31:0] csr_rvalue;
  logic        csr_we;
  logic [31:0] csr_wmask;
  logic [31:0] csr_wvalue;
  logic [31:0] csr_eentry;
  logic [31:0] csr_era;
  logic        wb_ex;
  logic [5:0]  wb_ecode;
  logic [8:0]  wb_esubcode;
  logic [31:0] wb_pc;
  logic        eret_flush;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        ms_flush;
  logic        flush_req;
  logic [31:0] flush_pc;
  logic        flush_ack;

  always #5 clk = ~clk;

  wb_csr_ctrl dut (
    .clk(clk), .resetn(resetn),
    .ms_valid(ms_valid), .ms_pc(ms_pc), .ms_csr_op(ms_csr_op), .ms_csr_num(ms_csr_num),
    .ms_rj_value(ms_rj_value), .ms_rkd_value(ms_rkd_value), .ms_ertn(ms_ertn),
    .ms_ex(ms_ex), .ms_ecode(ms_ecode), .ms_esubcode(ms_esubcode),
    .ms_gr_we(ms_gr_we), .ms_dest(ms_dest), .ms_result(ms_result),
    .ws_allowin(ws_allowin),
    .csr_re(csr_re), .csr_num(csr_num), .csr_rvalue(csr_rvalue),
    .csr_we(csr_we), .csr_wmask(csr_wmask), .csr_wvalue(csr_wvalue),
    .csr_eentry(csr_eentry), .csr_era(csr_era),
    .wb_ex(wb_ex), .wb_ecode(wb_ecode), .wb_esubcode(wb_esubcode), .wb_pc(wb_pc),
    .eret_flush(eret_flush),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .ms_flush(ms_flush), .flush_req(flush_req), .flush_pc(flush_pc), .flush_ack(flush_ack)
  );

`ifdef CSR_WR_FLUSH_EN
  localparam bit WR_FLUSH = 1'b1;
`else
  localparam bit WR_FLUSH = 1'b0;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: the instruction waiting in WB (if any), whether a
  // redirect is outstanding, and where it points.
  typedef struct {
    logic [31:0] pc;
    logic [1:0]  op;
    logic [13:0] num;
    logic [31:0] rj;
    logic [31:0] rkd;
    logic        ertn;
    logic        ex;
    logic [5:0]  ecode;
    logic [8:0]  esub;
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] result;
  } inst_t;

  bit          m_have;
  bit          m_redirect;
  logic [31:0] m_target;
  inst_t       m_inst;

  task automatic model_reset();
    m_have     = 1'b0;
    m_redirect = 1'b0;
    m_target   = 32'h0;
  endtask

  // What the pending instruction does when it retires this cycle
  function automatic int kind_now();
    // 0 none, 1 exception, 2 ertn, 3 csr op, 4 plain
    if (!m_have || m_redirect) return 0;
    if (m_inst.ex)             return 1;
    if (m_inst.ertn)           return 2;
    if (m_inst.op != 2'b00)    return 3;
    return 4;
  endfunction

  task automatic check_outputs();
    int   k;
    bit   writes_csr, retire, gpr;
    logic [31:0] e_mask;
    k          = kind_now();
    retire     = (k != 0);
    writes_csr = (k == 3) && (m_inst.op == 2'b10 || m_inst.op == 2'b11);
    gpr        = retire && m_inst.gr_we && (k != 1);
    e_mask     = (m_inst.op == 2'b10) ? 32'hFFFF_FFFF : m_inst.rj;
    check("ws_allowin", 32'(ws_allowin), 32'd1);
    check("csr_re",     32'(csr_re),     32'(k == 3));
    if (k == 3) check("csr_num", 32'(csr_num), 32'(m_inst.num));
    check("csr_we",     32'(csr_we),     32'(writes_csr));
    check("csr_wmask",  csr_wmask,       writes_csr ? e_mask : 32'h0);
    check("csr_wvalue", csr_wvalue,      writes_csr ? m_inst.rkd : 32'h0);
    check("wb_ex",      32'(wb_ex),      32'(k == 1));
    check("wb_ecode",   32'(wb_ecode),   (k == 1) ? 32'(m_inst.ecode) : 32'h0);
    check("wb_esub",    32'(wb_esubcode),(k == 1) ? 32'(m_inst.esub)  : 32'h0);
    check("wb_pc",      wb_pc,           (k == 1) ? m_inst.pc : 32'h0);
    check("eret_flush", 32'(eret_flush), 32'(k == 2));
    check("rf_we",      32'(rf_we),      32'(gpr));
    check("rf_waddr",   32'(rf_waddr),   gpr ? 32'(m_inst.dest) : 32'h0);
    check("rf_wdata",   rf_wdata,        gpr ? ((k == 3) ? csr_rvalue : m_inst.result) : 32'h0);
    check("flush_req",  32'(flush_req),  32'(m_redirect));
    check("flush_pc",   flush_pc,        m_target);
    check("ms_flush",   32'(ms_flush),
          32'(m_redirect || k == 1 || k == 2 || (WR_FLUSH && writes_csr)));
  endtask

  // Advance the model across one rising edge using the inputs now applied
  task automatic model_edge();
    int k;
    bit leaves;
    if (!resetn) begin
      model_reset();
      return;
    end
    if (m_redirect) begin
      if (flush_ack) m_redirect = 1'b0;
      m_have = 1'b0;
      return;
    end
    k      = kind_now();
    leaves = 1'b1;
    if (k == 1)      m_target = csr_eentry;
    else if (k == 2) m_target = csr_era;
    else if (k == 3 && WR_FLUSH && m_inst.op[1]) m_target = m_inst.pc + 32'd4;
    else leaves = 1'b0;
    m_redirect = leaves;
    m_have     = ms_valid && !leaves;
    if (m_have) begin
      m_inst.pc = ms_pc;          m_inst.op = ms_csr_op;     m_inst.num = ms_csr_num;
      m_inst.rj = ms_rj_value;    m_inst.rkd = ms_rkd_value; m_inst.ertn = ms_ertn;
      m_inst.ex = ms_ex;          m_inst.ecode = ms_ecode;   m_inst.esub = ms_esubcode;
      m_inst.gr_we = ms_gr_we;    m_inst.dest = ms_dest;     m_inst.result = ms_result;
    end
  endtask

  // Inputs are set by the caller shortly after a falling edge
  task automatic cyc();
    #1 check_outputs();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    ms_valid = 0; ms_pc = 0; ms_csr_op = 0; ms_csr_num = 0; ms_rj_value = 0;
    ms_rkd_value = 0; ms_ertn = 0; ms_ex = 0; ms_ecode = 0; ms_esubcode = 0;
    ms_gr_we = 0; ms_dest = 0; ms_result = 0; flush_ack = 0;
  endtask

  task automatic put_inst(input logic [31:0] pc, input logic [1:0] op, input logic [13:0] num,
                          input logic [31:0] rj, input logic [31:0] rkd, input logic ertn,
                          input logic ex, input logic [5:0] ecode, input logic gwe,
                          input logic [4:0] dest, input logic [31:0] res);
    ms_valid = 1; ms_pc = pc; ms_csr_op = op; ms_csr_num = num; ms_rj_value = rj;
    ms_rkd_value = rkd; ms_ertn = ertn; ms_ex = ex; ms_ecode = ecode; ms_esubcode = 9'h0;
    ms_gr_we = gwe; ms_dest = dest; ms_result = res;
  endtask

  task automatic random_inputs();
    ms_valid     = ($urandom_range(3) != 0);
    ms_pc        = $urandom();
    ms_csr_op    = 2'($urandom_range(3));
    ms_csr_num   = 14'($urandom());
    ms_rj_value  = $urandom();
    ms_rkd_value = $urandom();
    ms_ertn      = ($urandom_range(7) == 0);
    ms_ex        = ($urandom_range(7) == 0);
    ms_ecode     = 6'($urandom());
    ms_esubcode  = 9'($urandom());
    ms_gr_we     = 1'($urandom());
    ms_dest      = 5'($urandom());
    ms_result    = $urandom();
    csr_rvalue   = $urandom();
    csr_eentry   = $urandom();
    csr_era      = $urandom();
    flush_ack    = 1'($urandom());
  endtask

  initial begin
    idle_inputs();
    csr_rvalue = 0; csr_eentry = 0; csr_era = 0;
    resetn = 0;
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_flush_req", 32'(flush_req), 32'd0);
    check("rst_ms_flush",  32'(ms_flush),  32'd0);
    check("rst_allowin",   32'(ws_allowin), 32'd1);
    check_outputs();
    resetn = 1;

    // csrwr 0x30: write all bits, old value returned to the GPR
    put_inst(32'h1C00_0000, 2'b10, 14'h30, 32'h0, 32'h1234_5678, 0, 0, 6'h0, 1, 5'd4, 32'h5555);
    cyc();
    idle_inputs();
    csr_rvalue = 32'hAA;
    #1;
    check("tp_csrwr_we",    32'(csr_we), 32'd1);
    check("tp_csrwr_mask",  csr_wmask,   32'hFFFF_FFFF);
    check("tp_csrwr_wval",  csr_wvalue,  32'h1234_5678);
    check("tp_csrwr_rdata", rf_wdata,    32'hAA);
    cyc();
    check("tp_csrwr_once",  32'(csr_we), 32'd0);
    if (WR_FLUSH) begin
      flush_ack = 1;
      cyc();
      flush_ack = 0;
    end

    // csrxchg: masked write
    put_inst(32'h1C00_0010, 2'b11, 14'h4, 32'h0000_FF00, 32'hDEAD_BEEF, 0, 0, 6'h0, 1, 5'd7, 32'h0);
    cyc();
    idle_inputs();
    csr_rvalue = 32'h0F0F_0F0F;
    #1;
    check("tp_xchg_mask", csr_wmask,   32'h0000_FF00);
    check("tp_xchg_wval", csr_wvalue,  32'hDEAD_BEEF);
    check("tp_xchg_re",   32'(csr_re), 32'd1);
    cyc();
    if (WR_FLUSH) begin
      flush_ack = 1;
      cyc();
      flush_ack = 0;
    end

    // Exception: younger instruction offered during the commit is dropped
    csr_eentry = 32'h1C00_8000;
    put_inst(32'h1C00_0100, 2'b00, 14'h0, 32'h0, 32'h0, 0, 1, 6'h0B, 1, 5'd3, 32'h77);
    cyc();
    put_inst(32'h1C00_0104, 2'b00, 14'h0, 32'h0, 32'h0, 0, 0, 6'h0, 1, 5'd9, 32'h99);
    #1;
    check("tp_ex_pulse", 32'(wb_ex),    32'd1);
    check("tp_ex_ecode", 32'(wb_ecode), 32'h0B);
    check("tp_ex_pc",    wb_pc,         32'h1C00_0100);
    check("tp_ex_rfwe",  32'(rf_we),    32'd0);
    cyc();
    idle_inputs();
    flush_ack = 1;
    #1;
    check("tp_ex_freq", 32'(flush_req), 32'd1);
    check("tp_ex_fpc",  flush_pc,       32'h1C00_8000);
    check("tp_ex_gone", 32'(wb_ex),     32'd0);
    cyc();
    flush_ack = 0;
    cyc();
    check("tp_ex_drop", 32'(rf_we), 32'd0);

    // ertn with a slow acknowledge
    csr_era = 32'h1C00_0204;
    put_inst(32'h1C00_0200, 2'b00, 14'h0, 32'h0, 32'h0, 1, 0, 6'h0, 0, 5'd0, 32'h0);
    cyc();
    idle_inputs();
    #1 check("tp_ertn", 32'(eret_flush), 32'd1);
    cyc();
    for (int i = 0; i < 4; i++) begin
      flush_ack = (i == 3);
      #1;
      check("tp_ertn_freq", 32'(flush_req), 32'd1);
      check("tp_ertn_fpc",  flush_pc,       32'h1C00_0204);
      cyc();
    end
    flush_ack = 0;
    #1 check("tp_ertn_idle", 32'(flush_req), 32'd0);

    // Reset asserted while a redirect is outstanding
    put_inst(32'h1C00_0300, 2'b00, 14'h0, 32'h0, 32'h0, 0, 1, 6'h01, 0, 5'd0, 32'h0);
    cyc();
    idle_inputs();
    cyc();
    check("tp_rst_pre", 32'(flush_req), 32'd1);
    resetn = 0;
    #1;
    check("tp_rst_freq",  32'(flush_req), 32'd0);
    check("tp_rst_fpc",   flush_pc,       32'h0);
    check("tp_rst_msfl",  32'(ms_flush),  32'd0);
    model_reset();
    #2 resetn = 1;
    csr_rvalue = 32'h0000_00C3;
    put_inst(32'h1C00_0400, 2'b01, 14'h5, 32'h0, 32'h0, 0, 0, 6'h0, 1, 5'd12, 32'h0);
    cyc();
    idle_inputs();
    #1 check("tp_rst_after", rf_wdata, 32'h0000_00C3);
    cyc();

    // csrwr at the top of the address space
    put_inst(32'hFFFF_FFFC, 2'b10, 14'h0, 32'h0, 32'h1, 0, 0, 6'h0, 0, 5'd0, 32'h0);
    cyc();
    idle_inputs();
    cyc();
    check("tp_wrap_freq", 32'(flush_req), 32'(WR_FLUSH));
    if (WR_FLUSH) check("tp_wrap_fpc", flush_pc, 32'h0);
    flush_ack = 1;
    cyc();

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      random_inputs();
      cyc();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
